// File: rtl/watch_keypad_clock.sv
// watch_keypad_clock
//   Real-time HH:MM:SS watch loaded from a one-hot keypad. In set mode digits are
//   staged, range-checked, and committed atomically on the sixth valid digit.
//   Live time is kept as six BCD digits (index 0 = hour tens). Drives a multiplexed
//   8-digit 7-segment bank; only digits 7..2 are ever selected.
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   dip_sw        1 = set mode, 0 = run mode
//   keypad[9:0]   one-hot digit key, 0 = no key
//   mode_12h      1 = show hours in 12 h format
//   seg_data[7:0] segment pattern of the selected digit (8'h00 = blank)
//   seg_com[7:0]  active-low digit select
//   pm            live hour >= 12
//   time_set      a full entry has been committed since reset
module watch_keypad_clock #(
  parameter int CLK_HZ    = 1000,
  parameter int SCAN_DIV  = 1,
  parameter int BLINK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dip_sw,
  input  logic [9:0] keypad,
  input  logic       mode_12h,
  output logic [7:0] seg_data,
  output logic [7:0] seg_com,
  output logic       pm,
  output logic       time_set
);
  localparam int TW = $clog2(CLK_HZ + 1);
  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);

  typedef logic [5:0][3:0] digits_t;

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 8'h3F;
      4'd1:    seg_decode = 8'h06;
      4'd2:    seg_decode = 8'h5B;
      4'd3:    seg_decode = 8'h4F;
      4'd4:    seg_decode = 8'h66;
      4'd5:    seg_decode = 8'h6D;
      4'd6:    seg_decode = 8'h7D;
      4'd7:    seg_decode = 8'h07;
      4'd8:    seg_decode = 8'h7F;
      4'd9:    seg_decode = 8'h6F;
      default: seg_decode = 8'h00;
    endcase
  endfunction

  logic [9:0]    keypad_prev;
  logic          dip_prev;
  digits_t       stage, live, live_inc;
  logic [2:0]    idx, slot;
  logic [TW-1:0] tick_cnt;
  logic [SW-1:0] scan_cnt;
  logic [BW-1:0] blink_cnt;
  logic          blink_off;

  logic [3:0] key_val;
  logic       one_hot, key_ev, digit_ok, tick;
  logic [4:0] hour, h12;
  logic       tens12;
  logic [3:0] ones12;
  logic [7:0] disp_pat;

  always_comb begin
    key_val = 4'd0;
    for (int i = 0; i < 10; i++)
      if (keypad[i]) key_val = 4'(i);
  end

  assign one_hot = (keypad != 10'd0) && ((keypad & (keypad - 10'd1)) == 10'd0);
  // Fires only on the first cycle of a clean press; held or chorded keys are ignored.
  assign key_ev  = one_hot && (keypad_prev == 10'd0) && dip_sw;
  assign tick    = (tick_cnt == TW'(CLK_HZ - 1));

  always_comb begin
    case (idx)
      3'd0:      digit_ok = (key_val <= 4'd2);
      3'd1:      digit_ok = (stage[0] == 4'd2) ? (key_val <= 4'd3) : 1'b1;
      3'd2, 3'd4: digit_ok = (key_val <= 4'd5);
      default:   digit_ok = 1'b1;
    endcase
  end

  // +1 s ripple over BCD digits with 23:59:59 -> 00:00:00 wrap.
  always_comb begin
    live_inc = live;
    if (live[5] == 4'd9) begin
      live_inc[5] = 4'd0;
      if (live[4] == 4'd5) begin
        live_inc[4] = 4'd0;
        if (live[3] == 4'd9) begin
          live_inc[3] = 4'd0;
          if (live[2] == 4'd5) begin
            live_inc[2] = 4'd0;
            if (live[0] == 4'd2 && live[1] == 4'd3) begin
              live_inc[0] = 4'd0;
              live_inc[1] = 4'd0;
            end else if (live[1] == 4'd9) begin
              live_inc[1] = 4'd0;
              live_inc[0] = live[0] + 4'd1;
            end else begin
              live_inc[1] = live[1] + 4'd1;
            end
          end else live_inc[2] = live[2] + 4'd1;
        end else live_inc[3] = live[3] + 4'd1;
      end else live_inc[4] = live[4] + 4'd1;
    end else live_inc[5] = live[5] + 4'd1;
  end

  assign hour   = 5'(live[0]) * 5'd10 + 5'(live[1]);
  assign pm     = (hour >= 5'd12);
  assign h12    = (hour == 5'd0) ? 5'd12 : (hour > 5'd12) ? hour - 5'd12 : hour;
  assign tens12 = (h12 >= 5'd10);
  assign ones12 = tens12 ? 4'(h12 - 5'd10) : 4'(h12);

  always_comb begin
    disp_pat = 8'h00;
    if (dip_sw) begin
      if (slot < idx)       disp_pat = seg_decode(stage[slot]);
      else if (slot == idx) disp_pat = blink_off ? 8'h00 : seg_decode(4'd8);
    end else begin
      case (slot)
        3'd0:    disp_pat = mode_12h ? (tens12 ? seg_decode(4'd1) : 8'h00) : seg_decode(live[0]);
        3'd1:    disp_pat = mode_12h ? seg_decode(ones12) : seg_decode(live[1]);
        default: disp_pat = seg_decode(live[slot]);
      endcase
    end
  end

  // Time keeping and entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      keypad_prev <= '0;
      dip_prev    <= 1'b0;
      stage       <= '0;
      live        <= '0;
      idx         <= 3'd0;
      tick_cnt    <= '0;
      time_set    <= 1'b0;
    end else begin
      keypad_prev <= keypad;
      dip_prev    <= dip_sw;
      tick_cnt    <= tick ? '0 : tick_cnt + 1'b1;
      if (tick && time_set) live <= live_inc;
      if (key_ev && digit_ok) begin
        if (idx == 3'd5) begin
          // Commit wins over a same-edge tick and restarts the second.
          live     <= {key_val, stage[4:0]};
          tick_cnt <= '0;
          time_set <= 1'b1;
          idx      <= 3'd0;
          stage    <= '0;
        end else begin
          stage[idx] <= key_val;
          idx        <= idx + 3'd1;
        end
      end else if (dip_prev && !dip_sw && idx != 3'd0) begin
        stage <= '0;
        idx   <= 3'd0;
      end
    end
  end

  // Display scan, cursor blink, registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt  <= '0;
      slot      <= 3'd0;
      blink_cnt <= '0;
      blink_off <= 1'b0;
      seg_com   <= 8'hFF;
      seg_data  <= 8'h00;
    end else begin
      if (scan_cnt == SW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        slot     <= (slot == 3'd5) ? 3'd0 : slot + 3'd1;
      end else scan_cnt <= scan_cnt + 1'b1;
      if (blink_cnt == BW'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        blink_off <= ~blink_off;
      end else blink_cnt <= blink_cnt + 1'b1;
      seg_com  <= ~(8'h80 >> slot);
      seg_data <= disp_pat;
    end
  end
endmodule

// File: tb/tb_watch_keypad_clock.sv
module tb_watch_keypad_clock;
  localparam int CLK_HZ = 10, SCAN_DIV = 1, BLINK_DIV = 4;

  logic       clk = 1'b0, rst = 1'b1, dip_sw = 1'b0, mode_12h = 1'b0;
  logic [9:0] keypad = '0;
  logic [7:0] seg_data, seg_com;
  logic       pm, time_set;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;            // clock edges since the last reset edge

  // reference model state
  int m_idx = 0;
  int m_stg[6];
  bit m_set = 0;
  int m_base = 0, m_commit = 0;

  watch_keypad_clock #(.CLK_HZ(CLK_HZ), .SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .rst(rst), .dip_sw(dip_sw), .keypad(keypad), .mode_12h(mode_12h),
    .seg_data(seg_data), .seg_com(seg_com), .pm(pm), .time_set(time_set));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [7:0] seg7(input int d);
    case (d)
      0: return 8'h3F; 1: return 8'h06; 2: return 8'h5B; 3: return 8'h4F; 4: return 8'h66;
      5: return 8'h6D; 6: return 8'h7D; 7: return 8'h07; 8: return 8'h7F; 9: return 8'h6F;
      default: return 8'h00;
    endcase
  endfunction

  // Seconds of day shown by the live clock after k edges.
  function automatic int live_at(input int k);
    if (!m_set) return 0;
    return (m_base + (k - m_commit) / CLK_HZ) % 86400;
  endfunction

  function automatic logic [7:0] exp_pat(input int k, input int slot);
    int t, h, d[6];
    if (dip_sw) begin
      if (slot < m_idx) return seg7(m_stg[slot]);
      if (slot == m_idx) return ((k / BLINK_DIV) % 2) ? 8'h00 : seg7(8);
      return 8'h00;
    end
    t = live_at(k);
    h = t / 3600;
    if (mode_12h) h = (h % 12 == 0) ? 12 : h % 12;
    d[0] = h / 10; d[1] = h % 10;
    d[2] = (t / 60) % 60 / 10; d[3] = (t / 60) % 10;
    d[4] = (t % 60) / 10; d[5] = t % 10;
    if (slot == 0 && mode_12h && d[0] == 0) return 8'h00;
    return seg7(d[slot]);
  endfunction

  task automatic check_cycles(input int n);
    logic [7:0] sel;
    int k, slot;
    repeat (n) begin
      @(negedge clk);
      k = cyc - 1;
      slot = k % 6;
      sel = 8'h80 >> slot;
      sel = ~sel;
      chk("seg_com", seg_com, sel);
      chk("seg_data", seg_data, exp_pat(k, slot));
      chk("pm", pm, live_at(cyc) >= 12 * 3600);
      chk("time_set", time_set, m_set);
    end
  endtask

  task automatic model_key(input int k);
    bit ok;
    if (!dip_sw) return;
    case (m_idx)
      0: ok = (k <= 2);
      1: ok = (m_stg[0] == 2) ? (k <= 3) : 1'b1;
      2, 4: ok = (k <= 5);
      default: ok = 1'b1;
    endcase
    if (!ok) return;
    m_stg[m_idx] = k;
    if (m_idx == 5) begin
      m_base = (m_stg[0] * 10 + m_stg[1]) * 3600 + (m_stg[2] * 10 + m_stg[3]) * 60
               + m_stg[4] * 10 + m_stg[5];
      m_commit = cyc;
      m_set = 1;
      m_idx = 0;
    end else m_idx++;
  endtask

  task automatic press(input int k);
    @(negedge clk); keypad = 10'(1 << k);
    @(posedge clk); #1 model_key(k);
    @(negedge clk); keypad = '0;
    @(posedge clk);
  endtask

  task automatic enter(input int a, b, c, d, e, f);
    press(a); press(b); press(c); press(d); press(e); press(f);
  endtask

  task automatic set_dip(input logic v);
    @(negedge clk);
    if (dip_sw && !v) m_idx = 0;
    dip_sw = v;
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_seg_com", seg_com, 8'hFF);
    chk("rst_seg_data", seg_data, 8'h00);
    chk("rst_time_set", time_set, 1'b0);
    m_idx = 0; m_set = 0;
    chk("rst_pm", pm, 1'b0);
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    // 1: reset, free run without a committed time
    @(posedge clk); #1;
    chk("rst_seg_com", seg_com, 8'hFF);
    chk("rst_seg_data", seg_data, 8'h00);
    chk("rst_time_set", time_set, 1'b0);
    @(negedge clk); rst = 1'b0;
    check_cycles(100);

    // 2: commit 23:59:58 and roll over midnight
    set_dip(1'b1);
    enter(2, 3, 5, 9, 5, 8);
    #1 chk("time_set_after_commit", time_set, 1'b1);
    set_dip(1'b0);
    check_cycles(30);

    // 3: Ho range after Ht=2, cursor position visible on the display
    set_dip(1'b1);
    press(2); press(4); press(3);
    check_cycles(12);
    press(1);
    check_cycles(12);

    // 4: abandon entry, live clock unaffected, re-entry starts at Ht
    set_dip(1'b0);
    check_cycles(12);
    set_dip(1'b1);
    press(1); press(2);
    set_dip(1'b0);
    check_cycles(12);
    set_dip(1'b1);
    check_cycles(12);

    // 5: 12 h formatting
    enter(1, 3, 0, 5, 0, 0);
    set_dip(1'b0);
    @(negedge clk); mode_12h = 1'b1;
    check_cycles(18);
    set_dip(1'b1);
    enter(0, 0, 0, 0, 0, 0);
    set_dip(1'b0);
    check_cycles(18);
    @(negedge clk); mode_12h = 1'b0;

    // 6: held key, chorded key, reset mid-entry
    set_dip(1'b1);
    @(negedge clk); keypad = 10'b00_0000_0010;
    @(posedge clk); #1 model_key(1);
    repeat (49) @(posedge clk);
    @(negedge clk); keypad = 10'b00_0000_0011;
    repeat (5) @(posedge clk);
    @(negedge clk); keypad = '0;
    check_cycles(12);
    press(7);
    do_reset();
    check_cycles(12);

    // randomized entry sessions, random display mode
    repeat (4) begin
      set_dip(1'b1);
      repeat (14) press(int'($urandom_range(0, 9)));
      check_cycles(8);
      set_dip(1'b0);
      @(negedge clk); mode_12h = 1'($urandom_range(0, 1));
      check_cycles(25);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
